// File: rtl/rhs_chip_emulator_if.sv
// SPI pin bundle between rhs_spi_master (master) and the RHS2116 emulator (slave).
interface rhs_chip_emulator_if;
  logic SCLK;
  logic CS;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output CS, output MOSI, input MISO);
  modport slave  (input SCLK, input CS, input MOSI, output MISO);
endinterface

// File: rtl/rhs_chip_emulator.sv
// RHS2116 headstage emulator: oversampled SPI responder with register file and two-frame result latency.
// Optional ID ROM at READ addresses 251..254 is enabled by defining RHS_EMU_ROM_EN.
module rhs_chip_emulator (
  input  logic                 clk,
  input  logic                 rstn,
  rhs_chip_emulator_if.slave   spi,
  output logic                 cmd_valid,
  output logic [31:0]          cmd_word,
  output logic                 frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic        sclk_prev_reg, cs_prev_reg;
  logic [31:0] rx_shift_reg, tx_shift_reg;
  logic [5:0]  bit_cnt_reg;
  logic [31:0] r1_reg, r2_reg;
  logic [9:0]  conv_cnt_reg;
  logic [15:0] regs_reg [16];
  logic        cmd_valid_reg, frame_err_reg;
  logic [31:0] cmd_word_reg;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic load_tx, commit, bad_frame;

  assign sclk_s    = sclk_sync_reg[1];
  assign cs_s      = cs_sync_reg[1];
  assign mosi_s    = mosi_sync_reg[1];
  assign sclk_rise =  sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s &  sclk_prev_reg;
  assign cs_rise   =  cs_s & ~cs_prev_reg;
  assign cs_fall   = ~cs_s &  cs_prev_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], spi.SCLK};
      cs_sync_reg   <= {cs_sync_reg[0], spi.CS};
      mosi_sync_reg <= {mosi_sync_reg[0], spi.MOSI};
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
    end
  end

  // A CS rise while IDLE (e.g. synchronizers filling after reset) is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_tx    = 1'b0;
    commit     = 1'b0;
    bad_frame  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = DONE;
          commit     = (bit_cnt_reg == 6'd32);
          bad_frame  = (bit_cnt_reg != 6'd32);
        end
      end
      DONE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command decode of the completed frame
  logic [1:0]  op;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [15:0] conv_hi;
  logic [15:0] rd_data;
  logic [31:0] res;
  logic        wr_en, conv_inc, conv_clr;

  assign op      = rx_shift_reg[31:30];
  assign addr    = rx_shift_reg[23:16];
  assign data    = rx_shift_reg[15:0];
  assign conv_hi = {rx_shift_reg[21:16], conv_cnt_reg};

  always_comb begin
    rd_data = 16'h0000;
    if (addr[7:4] == 4'h0) begin
      rd_data = regs_reg[addr[3:0]];
    end else begin
      case (addr)
        8'd255: rd_data = 16'h0020;
`ifdef RHS_EMU_ROM_EN
        8'd251: rd_data = 16'h494E;
        8'd252: rd_data = 16'h5441;
        8'd253: rd_data = 16'h4E00;
        8'd254: rd_data = 16'h0001;
`endif
        default: rd_data = 16'h0000;
      endcase
    end
  end

  always_comb begin
    res      = 32'h0000_0000;
    wr_en    = 1'b0;
    conv_inc = 1'b0;
    conv_clr = 1'b0;
    case (op)
      2'b00: begin
        conv_inc = 1'b1;
        res      = {conv_hi, ~conv_hi};
      end
      2'b10: begin
        wr_en = (addr[7:4] == 4'h0);
        res   = {16'hFFFF, data};
      end
      2'b11: res = {16'h0000, rd_data};
      default: begin
        if (rx_shift_reg[29:24] == 6'h2A) begin
          conv_clr = 1'b1;
          res      = 32'h0000_0000;
        end else begin
          res      = 32'h8000_0000;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
      bit_cnt_reg   <= '0;
      r1_reg        <= '0;
      r2_reg        <= '0;
      conv_cnt_reg  <= '0;
      cmd_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      cmd_word_reg  <= '0;
    end else begin
      cmd_valid_reg <= commit;
      frame_err_reg <= bad_frame;
      if (load_tx) begin
        tx_shift_reg <= r2_reg;
        bit_cnt_reg  <= '0;
      end else if (state_reg == SHIFT) begin
        if (sclk_rise) begin
          rx_shift_reg <= {rx_shift_reg[30:0], mosi_s};
          // Saturate one past a full word so any overlong frame stays flagged bad
          if (bit_cnt_reg != 6'd33) bit_cnt_reg <= bit_cnt_reg + 6'd1;
        end
        if (sclk_fall) tx_shift_reg <= {tx_shift_reg[30:0], 1'b0};
      end
      if (commit) begin
        r1_reg       <= res;
        r2_reg       <= r1_reg;
        cmd_word_reg <= rx_shift_reg;
        if (conv_clr)      conv_cnt_reg <= '0;
        else if (conv_inc) conv_cnt_reg <= conv_cnt_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) regs_reg[i] <= '0;
    end else if (commit && wr_en) begin
      regs_reg[addr[3:0]] <= data;
    end
  end

  assign spi.MISO  = (state_reg == SHIFT) & tx_shift_reg[31];
  assign cmd_valid = cmd_valid_reg;
  assign cmd_word  = cmd_word_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_rhs_chip_emulator.sv
// Self-checking bench for rhs_chip_emulator: behavioural command/pipeline model, directed cases, random frames.
`timescale 1ns/1ps
module tb_rhs_chip_emulator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid, frame_err;
  logic [31:0] cmd_word;

  always #5 clk = ~clk;

  rhs_chip_emulator_if ifc();

  rhs_chip_emulator dut (
    .clk       (clk),
    .rstn      (rstn),
    .spi       (ifc),
    .cmd_valid (cmd_valid),
    .cmd_word  (cmd_word),
    .frame_err (frame_err)
  );

  int          total = 0;
  int          bad = 0;
  logic [15:0] m_regs [16];
  int          m_conv;
  logic [31:0] m_pipe [$];
  logic [31:0] exp_cmd_q [$];
  int          err_pending = 0;
  logic [31:0] exp_cmd_word = '0;
  int          cs_hi_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] data);
    return {op, 6'h00, addr, data};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_conv = 0;
    m_pipe.delete();
    m_pipe.push_back(32'h0);
    m_pipe.push_back(32'h0);
    exp_cmd_q.delete();
    err_pending = 0;
  endtask

  // What the chip answers to word w, two frames later
  task automatic model_exec(input logic [31:0] w, output logic [31:0] res);
    int          addr;
    logic [15:0] data, hi, rd;
    addr = int'(w[23:16]);
    data = w[15:0];
    case (w[31:30])
      2'b00: begin
        hi = 16'(int'(w[21:16]) * 1024 + m_conv);
        res = {hi, ~hi};
        m_conv = (m_conv + 1) % 1024;
      end
      2'b10: begin
        if (addr < 16) m_regs[addr] = data;
        res = {16'hFFFF, data};
      end
      2'b11: begin
        rd = 16'h0000;
        if (addr < 16) rd = m_regs[addr];
        else if (addr == 255) rd = 16'h0020;
`ifdef RHS_EMU_ROM_EN
        else if (addr == 251) rd = 16'h494E;
        else if (addr == 252) rd = 16'h5441;
        else if (addr == 253) rd = 16'h4E00;
        else if (addr == 254) rd = 16'h0001;
`endif
        res = {16'h0000, rd};
      end
      default: begin
        if (w[29:24] == 6'h2A) begin
          m_conv = 0;
          res = 32'h0000_0000;
        end else begin
          res = 32'h8000_0000;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    ifc.CS = 1'b1;
    ifc.SCLK = 1'b0;
    ifc.MOSI = 1'b0;
    clk_wait(3);
    model_reset();
    rstn = 1'b1;
    clk_wait(6);
  endtask

  // One SPI frame of nbits; MISO sampled at the end of each SCLK low phase
  task automatic frame(input logic [31:0] w, input int nbits, output logic [31:0] got);
    logic [63:0] cap, expc;
    logic [31:0] exp_word, res;
    cap = '0;
    expc = '0;
    exp_word = m_pipe[0];
    ifc.CS = 1'b0;
    clk_wait(6);
    for (int i = 0; i < nbits; i++) begin
      ifc.MOSI = (i < 32) ? w[31-i] : 1'b0;
      clk_wait(5);
      cap  = {cap[62:0], ifc.MISO};
      expc = {expc[62:0], (i < 32) ? exp_word[31-i] : 1'b0};
      ifc.SCLK = 1'b1;
      clk_wait(5);
      ifc.SCLK = 1'b0;
    end
    clk_wait(5);
    if (nbits == 32) begin
      model_exec(w, res);
      void'(m_pipe.pop_front());
      m_pipe.push_back(res);
      exp_cmd_q.push_back(w);
    end else begin
      err_pending++;
    end
    ifc.CS = 1'b1;
    clk_wait(10);
    check($sformatf("miso_bits n=%0d cmd=%08h", nbits, w), cap, expc);
    check("pulses_seen", 64'(exp_cmd_q.size() + err_pending), 64'd0);
    got = cap[31:0];
  endtask

  // Every-cycle comparison of the status outputs against the model's expectations
  always @(negedge clk) begin
    if (!rstn) begin
      exp_cmd_word = '0;
      cs_hi_cnt = 0;
    end else begin
      if (exp_cmd_q.size() == 0) check("cmd_valid_idle", 64'(cmd_valid), 64'd0);
      else if (cmd_valid) exp_cmd_word = exp_cmd_q.pop_front();
      check("cmd_word", 64'(cmd_word), 64'(exp_cmd_word));
      if (err_pending == 0) check("frame_err_idle", 64'(frame_err), 64'd0);
      else if (frame_err) err_pending--;
      cs_hi_cnt = ifc.CS ? cs_hi_cnt + 1 : 0;
      if (cs_hi_cnt >= 5) check("miso_cs_high", 64'(ifc.MISO), 64'd0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] t3 [5];
    logic [31:0] w;
    int          r, nb, a;

    ifc.CS = 1'b1;
    ifc.SCLK = 1'b0;
    ifc.MOSI = 1'b0;
    model_reset();
    clk_wait(3);
    check("rst_miso", 64'(ifc.MISO), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_cmd_word", 64'(cmd_word), 64'd0);
    rstn = 1'b1;
    clk_wait(6);

    // Chip ID through the two-frame pipeline
    frame(mk(2'b11, 8'd255, 16'h0), 32, got);
    check("id_f1", 64'(got), 64'h0);
    frame(mk(2'b00, 8'd0, 16'h0), 32, got);
    frame(mk(2'b00, 8'd0, 16'h0), 32, got);
    check("id_f3", 64'(got), 64'h0000_0020);

    // Write then read back in the next frame
    do_reset();
    frame(mk(2'b10, 8'd3, 16'hBEEF), 32, got);
    frame(mk(2'b11, 8'd3, 16'h0), 32, got);
    frame(mk(2'b00, 8'd0, 16'h0), 32, got);
    check("wr_echo", 64'(got), 64'hFFFF_BEEF);
    frame(mk(2'b00, 8'd0, 16'h0), 32, got);
    check("rd_back", 64'(got), 64'h0000_BEEF);

    // Conversion counter on channel 31
    do_reset();
    t3[0] = 32'h7C00_83FF;
    t3[1] = 32'h7C01_83FE;
    t3[2] = 32'h7C02_83FD;
    t3[3] = 32'h7C03_83FC;
    t3[4] = 32'h7C04_83FB;
    for (int k = 0; k < 7; k++) begin
      frame((k < 5) ? mk(2'b00, 8'd31, 16'h0) : mk(2'b11, 8'd0, 16'h0), 32, got);
      if (k >= 2) check($sformatf("conv31_%0d", k - 2), 64'(got), 64'(t3[k-2]));
    end

    // Short frame between valid frames must not disturb the pipeline
    do_reset();
    frame(mk(2'b00, 8'd1, 16'h0), 32, got);
    frame(32'hFFFF_FFFF, 20, got);
    frame(mk(2'b00, 8'd2, 16'h0), 32, got);
    check("short_f3", 64'(got), 64'h0);
    frame(mk(2'b11, 8'd0, 16'h0), 32, got);
    check("short_f4", 64'(got), 64'h0400_FBFF);
    frame(mk(2'b11, 8'd0, 16'h0), 32, got);
    check("short_f5", 64'(got), 64'h0801_F7FE);

    // ROM read
    do_reset();
    frame(mk(2'b11, 8'd251, 16'h0), 32, got);
    frame(mk(2'b00, 8'd0, 16'h0), 32, got);
    frame(mk(2'b00, 8'd0, 16'h0), 32, got);
`ifdef RHS_EMU_ROM_EN
    check("rom_251", 64'(got), 64'h0000_494E);
`else
    check("rom_251", 64'(got), 64'h0000_0000);
`endif

    // Reset in the middle of a frame
    do_reset();
    frame(mk(2'b10, 8'd20, 16'h1234), 32, got);
    frame(mk(2'b10, 8'd21, 16'h5678), 32, got);
    ifc.CS = 1'b0;
    clk_wait(6);
    for (int i = 0; i < 12; i++) begin
      ifc.MOSI = 1'b1;
      clk_wait(5);
      ifc.SCLK = 1'b1;
      clk_wait(5);
      ifc.SCLK = 1'b0;
    end
    clk_wait(5);
    check("midrst_pre_miso", 64'(ifc.MISO), 64'd1);
    rstn = 1'b0;
    #1;
    check("midrst_miso", 64'(ifc.MISO), 64'd0);
    ifc.CS = 1'b1;
    clk_wait(3);
    model_reset();
    rstn = 1'b1;
    clk_wait(6);
    frame(mk(2'b11, 8'd255, 16'h0), 32, got);
    check("midrst_f1", 64'(got), 64'h0);
    frame(mk(2'b11, 8'd255, 16'h0), 32, got);
    check("midrst_f2", 64'(got), 64'h0);

    // Randomized frames against the model
    do_reset();
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0, 1: a = $urandom_range(0, 15);
        2:    a = $urandom_range(16, 250);
        default: a = $urandom_range(251, 255);
      endcase
      nb = 32;
      if (r <= 2) begin
        w = mk(2'b00, 8'($urandom_range(0, 63)), 16'($urandom));
      end else if (r <= 4) begin
        w = mk(2'b10, 8'(a), 16'($urandom));
      end else if (r <= 7) begin
        w = mk(2'b11, 8'(a), 16'($urandom));
      end else if (r == 8) begin
        w = {2'b01, 30'($urandom)};
        if ($urandom_range(0, 1) == 1) w[29:24] = 6'h2A;
      end else begin
        w = $urandom;
        nb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : $urandom_range(33, 40);
      end
      frame(w, nb, got);
    end

    clk_wait(10);
    check("final_drain", 64'(exp_cmd_q.size() + err_pending), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rhs_chip_emulator.md
# rhs_chip_emulator

Synthesizable RHS2116 headstage-chip emulator: the SPI responder that `rhs_spi_master` talks to, for hardware-in-the-loop bring-up when no Intan headstage is attached. It oversamples SCLK/CS/MOSI in the FPGA clock domain and decodes 32-bit command words. It holds a small register file and returns deterministic conversion data on MISO with the chip's two-command result latency.

## Interface
- No parameters.
- `clk`  in  1  system clock (112 MHz nominal); all logic is on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `SCLK`  in  1  SPI clock from the master; idles low; asynchronous to `clk`.
- `CS`  in  1  active-low frame select; one 32-bit word per low period.
- `MOSI`  in  1  command bit, MSB first, valid at rising SCLK.
- `MISO`  out  1  response bit, MSB first, changes after falling SCLK.
- `cmd_valid`  out  1  one-`clk` pulse when a complete 32-bit word has been decoded.
- `cmd_word`  out  32  last complete command word; holds until the next one.
- `frame_err`  out  1  one-`clk` pulse when CS rises with bit count ≠ 32.

## Operation
- SCLK, CS and MOSI each pass through a 2-flop synchronizer. Edges are detected on the synchronized copies.
- While CS is low, a rising SCLK shifts MOSI into `rx_shift[31:0]` and increments a 6-bit `bit_cnt`. A count above 32 saturates and marks the frame bad.
- Falling CS clears `bit_cnt` and loads `tx_shift` from pipeline stage `r2`. `MISO` then drives `tx_shift[31]`.
- Each falling SCLK with CS low shifts `tx_shift` left by one and fills the LSB with 0.
- When CS is high, `MISO` is 0.
- Rising CS with `bit_cnt == 32` completes the frame:
  - decode `rx_shift` into result `res`;
  - `r2 <= r1`, `r1 <= res`;
  - pulse `cmd_valid` and update `cmd_word`.
- Net effect: the result of command N is shifted out during command N+2.
- Rising CS with `bit_cnt != 32` pulses `frame_err`. It does not decode, does not advance the pipeline and does not write registers.
- Decode uses `op = w[31:30]`, `addr = w[23:16]`, `data = w[15:0]`, `ch = w[21:16]`:
  - `00` CONVERT: increment 10-bit `conv_cnt` (wraps at 1023→0). `res = {hi, ~hi}`, where `hi = {ch, conv_cnt_before_increment}`.
  - `10` WRITE: if `addr < 16`, `regs[addr[3:0]] <= data`. `res = {16'hFFFF, data}`; writes to `addr ≥ 16` are ignored but still echo `data`.
  - `11` READ: `res = {16'h0000, rd}`. `rd = regs[addr[3:0]]` if `addr < 16`; 255 returns chip ID 16'h0020; ROM per Configuration; otherwise 0.
  - `01` with `w[29:24] == 6'h2A` (CLEAR) resets `conv_cnt` to 0 and returns `res = 32'h0000_0000`.
  - Any other `01` word returns `res = 32'h8000_0000`.
- A write is visible to a READ issued in the very next frame.

## Timing
- Reset values: `MISO=0`, `cmd_valid=0`, `frame_err=0`, `cmd_word=0`, `r1=r2=0`, `regs=0`, `conv_cnt=0`, `bit_cnt=0`, synchronizers=0.
- Pin-to-action latency is 3 `clk` cycles (2 synchronizer cycles plus 1 edge-detect register):
  - falling CS → `MISO` valid;
  - falling SCLK → next `MISO` bit;
  - rising CS → `cmd_valid`.
- Master constraints:
  - SCLK high and low phases ≥ 4 `clk` each;
  - CS high time between frames ≥ 4 `clk`;
  - CS-fall to first SCLK rise ≥ 4 `clk`.
- States: IDLE (CS high) → SHIFT (CS low) → on CS rise, DONE (1 cycle: decode/pulse) → IDLE.
- A CS fall in the DONE cycle is still honored: `tx_shift` loads the newly shifted `r2`.
- Asserting `rstn` mid-frame immediately clears all state. The frame in progress is lost, and the next complete frame starts from reset pipeline contents.

## Configuration
- `RHS_EMU_ROM_EN` defined: READs of 251–254 return the ASCII ROM 16'h494E ("IN"), 16'h5441 ("TA"), 16'h4E00 ("N\0"), 16'h0001 (die revision).
- `RHS_EMU_ROM_EN` undefined: those addresses read 0. The chip ID at 255 is always present.

## Test plan
- Reset, then issue READ 255, then two CONVERT ch 0 → the third frame's MISO word = 32'h0000_0020.
- WRITE addr 3 data 16'hBEEF, READ 3, CONVERT, CONVERT → the frames return 32'hFFFF_BEEF then 32'h0000_BEEF, in frames 3 and 4.
- Five CONVERTs on ch 31 from reset, then two dummies → responses in order `hi` = 16'h7C00..16'h7C04, each paired with the inverted low half (e.g. 32'h7C00_83FF).
- A 20-bit frame between valid frames → `frame_err` pulses once, `cmd_valid` does not, and the pipeline and response order are unchanged.
- With `RHS_EMU_ROM_EN`, READ 251 → 32'h0000_494E two frames later; without it → 32'h0000_0000.
- Assert `rstn` low mid-frame after 12 bits → `MISO=0` immediately; the next two frames return 32'h0000_0000.
